// File: rtl/cue_aim_controller.sv
// Cue aiming controller: keyboard-driven angle/power, sin/cos line vector,
// and a valid/ack shot handoff that waits for the table to settle.
module cue_aim_controller #(
    parameter int REPEAT_FRAMES = 4,
    parameter int POWER_MIN     = 16,
    parameter int POWER_MAX     = 192,
    parameter int POWER_STEP    = 4,
    parameter int SPEED_SHIFT   = 3
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               keyLeft,
    input  logic               keyRight,
    input  logic               keyUp,
    input  logic               keyDown,
    input  logic               keyEnterIsPressed,
    input  logic               ballsMoving,
    input  logic               shotAck,
    output logic signed [10:0] velocityX,
    output logic signed [10:0] velocityY,
    output logic               drawLineEnable,
    output logic signed [10:0] shotVelocityX,
    output logic signed [10:0] shotVelocityY,
    output logic               shotValid,
    output logic [5:0]         angle
);

    localparam int CNT_W = (REPEAT_FRAMES > 1) ? $clog2(REPEAT_FRAMES) : 1;

    typedef enum logic [1:0] {AIM, FIRE, WAIT_START, WAIT_STOP} state_t;

    state_t                state_q, state_d;
    logic [5:0]            angle_q, angle_d;
    logic [7:0]            power_q, power_d;
    logic [CNT_W-1:0]      rot_cnt_q, rot_cnt_d;
    logic [CNT_W-1:0]      pwr_cnt_q, pwr_cnt_d;
    logic                  enter_prev_q, enter_prev_d;
    logic                  shot_valid_q, shot_valid_d;
    logic                  draw_q, draw_d;
    logic signed [10:0]    shot_vx_q, shot_vx_d;
    logic signed [10:0]    shot_vy_q, shot_vy_d;
    logic signed [15:0]    prod_x_p1_q, prod_x_p1_d;
    logic signed [15:0]    prod_y_p1_q, prod_y_p1_d;
    logic signed [10:0]    vel_x_p2_q, vel_x_p2_d;
    logic signed [10:0]    vel_y_p2_q, vel_y_p2_d;
    logic                  enter_edge;
    logic                  rot_active, pwr_active;

    // Quarter-wave Q6 sine with quadrant mirroring; 64 represents 1.0.
    function automatic logic signed [7:0] sin_q6(input logic [5:0] a);
        logic [4:0] idx;
        logic [6:0] mag;
        idx = a[4] ? (5'd16 - {1'b0, a[3:0]}) : {1'b0, a[3:0]};
        case (idx)
            5'd0:  mag = 7'd0;
            5'd1:  mag = 7'd6;
            5'd2:  mag = 7'd12;
            5'd3:  mag = 7'd19;
            5'd4:  mag = 7'd24;
            5'd5:  mag = 7'd30;
            5'd6:  mag = 7'd36;
            5'd7:  mag = 7'd41;
            5'd8:  mag = 7'd45;
            5'd9:  mag = 7'd49;
            5'd10: mag = 7'd53;
            5'd11: mag = 7'd56;
            5'd12: mag = 7'd59;
            5'd13: mag = 7'd61;
            5'd14: mag = 7'd63;
            5'd15: mag = 7'd64;
            5'd16: mag = 7'd64;
            default: mag = 7'd0;
        endcase
        return a[5] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
    endfunction

    function automatic logic signed [15:0] mul_q6(input logic signed [7:0] s,
                                                  input logic [7:0] p);
        logic signed [15:0] a;
        logic signed [15:0] b;
        a = 16'(s);
        b = $signed({8'd0, p});
        return a * b;
    endfunction

    function automatic logic signed [10:0] asr6(input logic signed [15:0] p);
        logic signed [15:0] t;
        t = p >>> 6;
        return t[10:0];
    endfunction

    function automatic logic [7:0] power_up(input logic [7:0] p);
        logic [9:0] s;
        s = {2'b00, p} + 10'(POWER_STEP);
        return (s > 10'(POWER_MAX)) ? 8'(POWER_MAX) : s[7:0];
    endfunction

    function automatic logic [7:0] power_down(input logic [7:0] p);
        return ({2'b00, p} < 10'(POWER_MIN + POWER_STEP)) ? 8'(POWER_MIN)
                                                          : p - 8'(POWER_STEP);
    endfunction

    // Auto-repeat: step when the counter is at zero, wrap every REPEAT_FRAMES.
    function automatic logic [CNT_W-1:0] rep_next(input logic active,
                                                  input logic [CNT_W-1:0] cnt);
        if (!active)
            return '0;
        else if (cnt == CNT_W'(REPEAT_FRAMES - 1))
            return '0;
        else
            return cnt + 1'b1;
    endfunction

    assign enter_edge = keyEnterIsPressed & ~enter_prev_q;
    assign rot_active = keyLeft ^ keyRight;
    assign pwr_active = keyUp ^ keyDown;

    always_comb begin
        state_d      = state_q;
        angle_d      = angle_q;
        power_d      = power_q;
        rot_cnt_d    = rot_cnt_q;
        pwr_cnt_d    = pwr_cnt_q;
        shot_valid_d = shot_valid_q;
        draw_d       = draw_q;
        shot_vx_d    = shot_vx_q;
        shot_vy_d    = shot_vy_q;
        enter_prev_d = keyEnterIsPressed;

        case (state_q)
            AIM: begin
                if (startOfFrame) begin
                    if (rot_active && rot_cnt_q == '0)
                        angle_d = keyLeft ? angle_q + 6'd1 : angle_q - 6'd1;
                    if (pwr_active && pwr_cnt_q == '0)
                        power_d = keyUp ? power_up(power_q) : power_down(power_q);
                    rot_cnt_d = rep_next(rot_active, rot_cnt_q);
                    pwr_cnt_d = rep_next(pwr_active, pwr_cnt_q);
                end
                // The shot takes the vector already on the outputs, before any same-cycle step.
                if (enter_edge) begin
                    state_d      = FIRE;
                    shot_valid_d = 1'b1;
                    draw_d       = 1'b0;
                    shot_vx_d    = vel_x_p2_q >>> SPEED_SHIFT;
                    shot_vy_d    = vel_y_p2_q >>> SPEED_SHIFT;
                end
            end
            FIRE: begin
                rot_cnt_d = '0;
                pwr_cnt_d = '0;
                if (shotAck) begin
                    state_d      = WAIT_START;
                    shot_valid_d = 1'b0;
                end
            end
            WAIT_START: begin
                rot_cnt_d = '0;
                pwr_cnt_d = '0;
                if (ballsMoving)
                    state_d = WAIT_STOP;
            end
            default: begin
                rot_cnt_d = '0;
                pwr_cnt_d = '0;
                if (!ballsMoving) begin
                    state_d = AIM;
                    power_d = 8'(POWER_MIN);
                    draw_d  = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        prod_x_p1_d = mul_q6(sin_q6(angle_q + 6'd16), power_q);
        prod_y_p1_d = mul_q6(sin_q6(angle_q), power_q);
        vel_x_p2_d  = asr6(prod_x_p1_q);
        vel_y_p2_d  = -asr6(prod_y_p1_q);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q      <= AIM;
            angle_q      <= '0;
            power_q      <= 8'(POWER_MIN);
            rot_cnt_q    <= '0;
            pwr_cnt_q    <= '0;
            enter_prev_q <= 1'b1;
            shot_valid_q <= 1'b0;
            draw_q       <= 1'b1;
            shot_vx_q    <= '0;
            shot_vy_q    <= '0;
            prod_x_p1_q  <= 16'(64 * POWER_MIN);
            prod_y_p1_q  <= '0;
            vel_x_p2_q   <= 11'(POWER_MIN);
            vel_y_p2_q   <= '0;
        end else begin
            state_q      <= state_d;
            angle_q      <= angle_d;
            power_q      <= power_d;
            rot_cnt_q    <= rot_cnt_d;
            pwr_cnt_q    <= pwr_cnt_d;
            enter_prev_q <= enter_prev_d;
            shot_valid_q <= shot_valid_d;
            draw_q       <= draw_d;
            shot_vx_q    <= shot_vx_d;
            shot_vy_q    <= shot_vy_d;
            // p1: table lookup and multiply; p2: scale and sign for screen axes
            prod_x_p1_q  <= prod_x_p1_d;
            prod_y_p1_q  <= prod_y_p1_d;
            vel_x_p2_q   <= vel_x_p2_d;
            vel_y_p2_q   <= vel_y_p2_d;
        end
    end

    assign velocityX      = vel_x_p2_q;
    assign velocityY      = vel_y_p2_q;
    assign drawLineEnable = draw_q;
    assign shotVelocityX  = shot_vx_q;
    assign shotVelocityY  = shot_vy_q;
    assign shotValid      = shot_valid_q;
    assign angle          = angle_q;

endmodule
